// File: rtl/smem_mem_arbiter.sv
// smem_mem_arbiter: round-robin arbiter sharing one paired k/l memory-read
// port among NUM_ENG SMEM engines. Outstanding pairs are bounded by a credit
// counter; an in-order tag FIFO steers each returning pair to its requester.
module smem_mem_arbiter #(
   parameter int unsigned NUM_ENG   = 4,
   parameter int unsigned ADDR_W    = 58,
   parameter int unsigned RN_W      = 6,
   parameter int unsigned MAX_OUTST = 16
) (
   input  logic                             CLK_200M,
   input  logic                             spl_reset,
   input  logic                             stall,
   input  logic [NUM_ENG-1:0]               eng_req_valid,
   output logic [NUM_ENG-1:0]               eng_req_ready,
   input  logic [NUM_ENG*ADDR_W-1:0]        eng_req_addr_k,
   input  logic [NUM_ENG*ADDR_W-1:0]        eng_req_addr_l,
   input  logic [NUM_ENG*RN_W-1:0]          eng_req_read_num,
   output logic                             mem_req_valid,
   output logic [ADDR_W-1:0]                mem_req_addr_k,
   output logic [ADDR_W-1:0]                mem_req_addr_l,
   output logic [RN_W-1:0]                  mem_req_read_num,
   input  logic                             mem_rsp_valid,
   input  logic [511:0]                     mem_rsp_k,
   input  logic [511:0]                     mem_rsp_l,
   output logic [NUM_ENG-1:0]               eng_rsp_valid,
   output logic [511:0]                     eng_rsp_k,
   output logic [511:0]                     eng_rsp_l,
   output logic [RN_W-1:0]                  eng_rsp_read_num,
   output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding,
   output logic                             idle,
   output logic                             err_orphan
);

   localparam int unsigned ID_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   idx_v;
   logic              grant_found;
   logic              can_grant;
   logic              xfer;
   logic              pop;
   logic              tag_empty;
   logic [ADDR_W-1:0] sel_k;
   logic [ADDR_W-1:0] sel_l;
   logic [RN_W-1:0]   sel_rn;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ID_W-1:0]   tag_id [2**PTR_W];
   logic [RN_W-1:0]   tag_rn [2**PTR_W];

   // Round-robin search starting after the last winner, credit/stall gating
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      idx_v       = '0;
      for (int unsigned k = 1; k <= NUM_ENG; k++) begin
         idx_v = ID_W'((32'(rr_ptr) + k) % NUM_ENG);
         if (!grant_found && eng_req_valid[idx_v]) begin
            grant_found = 1'b1;
            grant_idx   = idx_v;
         end
      end
      tag_empty     = (outstanding == '0);
      can_grant     = !stall && (outstanding < CNT_W'(MAX_OUTST));
      xfer          = can_grant && grant_found && !spl_reset;
      pop           = mem_rsp_valid && !tag_empty;
      eng_req_ready = '0;
      if (xfer) eng_req_ready[grant_idx] = 1'b1;
      sel_k  = eng_req_addr_k[32'(grant_idx)*ADDR_W +: ADDR_W];
      sel_l  = eng_req_addr_l[32'(grant_idx)*ADDR_W +: ADDR_W];
      sel_rn = eng_req_read_num[32'(grant_idx)*RN_W +: RN_W];
   end

   assign idle = (outstanding == '0) && !mem_req_valid;

   // Register the winning request onto the memory port and advance rr_ptr
   always_ff @(posedge CLK_200M) begin
      if (spl_reset) begin
         mem_req_valid    <= 1'b0;
         mem_req_addr_k   <= '0;
         mem_req_addr_l   <= '0;
         mem_req_read_num <= '0;
         rr_ptr           <= ID_W'(NUM_ENG - 1);
      end else begin
         mem_req_valid <= xfer;
         if (xfer) begin
            mem_req_addr_k   <= sel_k;
            mem_req_addr_l   <= sel_l;
            mem_req_read_num <= sel_rn;
            rr_ptr           <= grant_idx;
         end
      end
   end

   // Tag FIFO storage; emptiness is tracked by the pointers and the counter
   always_ff @(posedge CLK_200M) begin
      if (xfer) begin
         tag_id[wr_ptr] <= grant_idx;
         tag_rn[wr_ptr] <= sel_rn;
      end
   end

   // FIFO pointers, credit counter and sticky orphan-response flag
   always_ff @(posedge CLK_200M) begin
      if (spl_reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         err_orphan  <= 1'b0;
      end else begin
         if (xfer) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({xfer, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (mem_rsp_valid && tag_empty) err_orphan <= 1'b1;
      end
   end

   // Steer each returning pair to the engine recorded at the FIFO head
   always_ff @(posedge CLK_200M) begin
      if (spl_reset) begin
         eng_rsp_valid    <= '0;
         eng_rsp_k        <= '0;
         eng_rsp_l        <= '0;
         eng_rsp_read_num <= '0;
      end else begin
         eng_rsp_valid <= '0;
         if (pop) begin
            eng_rsp_valid[tag_id[rd_ptr]] <= 1'b1;
            eng_rsp_k                     <= mem_rsp_k;
            eng_rsp_l                     <= mem_rsp_l;
            eng_rsp_read_num              <= tag_rn[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_smem_mem_arbiter.sv
// Scoreboard bench for smem_mem_arbiter: stimulus pushes expected memory
// requests and engine responses; a negedge monitor pops and compares.
module tb_smem_mem_arbiter;

   localparam int NE = 4;
   localparam int AW = 58;
   localparam int RW = 6;
   localparam int MO = 16;

   logic              CLK_200M = 1'b0;
   logic              spl_reset, stall;
   logic [NE-1:0]     eng_req_valid, eng_req_ready;
   logic [NE*AW-1:0]  eng_req_addr_k, eng_req_addr_l;
   logic [NE*RW-1:0]  eng_req_read_num;
   logic              mem_req_valid;
   logic [AW-1:0]     mem_req_addr_k, mem_req_addr_l;
   logic [RW-1:0]     mem_req_read_num;
   logic              mem_rsp_valid;
   logic [511:0]      mem_rsp_k, mem_rsp_l;
   logic [NE-1:0]     eng_rsp_valid;
   logic [511:0]      eng_rsp_k, eng_rsp_l;
   logic [RW-1:0]     eng_rsp_read_num;
   logic [4:0]        outstanding;
   logic              idle, err_orphan;

   logic [AW-1:0] ek [NE];
   logic [AW-1:0] el [NE];
   logic [RW-1:0] er [NE];

   typedef struct {
      logic [AW-1:0] k;
      logic [AW-1:0] l;
      logic [RW-1:0] rn;
   } req_t;
   typedef struct {
      logic [NE-1:0] oh;
      logic [RW-1:0] rn;
      logic [511:0]  k;
      logic [511:0]  l;
   } rsp_t;

   req_t exp_req [$];
   rsp_t exp_rsp [$];
   req_t rq_m;
   rsp_t rs_m;
   rsp_t rs_e;

   int checks   = 0;
   int failures = 0;
   int grants;
   int ord [4] = '{1, 3, 1, 0};

   smem_mem_arbiter #(.NUM_ENG(NE), .ADDR_W(AW), .RN_W(RW), .MAX_OUTST(MO)) dut (
      .CLK_200M(CLK_200M), .spl_reset(spl_reset), .stall(stall),
      .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
      .eng_req_addr_k(eng_req_addr_k), .eng_req_addr_l(eng_req_addr_l),
      .eng_req_read_num(eng_req_read_num),
      .mem_req_valid(mem_req_valid), .mem_req_addr_k(mem_req_addr_k),
      .mem_req_addr_l(mem_req_addr_l), .mem_req_read_num(mem_req_read_num),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_k(mem_rsp_k), .mem_rsp_l(mem_rsp_l),
      .eng_rsp_valid(eng_rsp_valid), .eng_rsp_k(eng_rsp_k), .eng_rsp_l(eng_rsp_l),
      .eng_rsp_read_num(eng_rsp_read_num), .outstanding(outstanding),
      .idle(idle), .err_orphan(err_orphan)
   );

   always #5 CLK_200M = ~CLK_200M;

   always_comb begin
      eng_req_addr_k   = '0;
      eng_req_addr_l   = '0;
      eng_req_read_num = '0;
      for (int i = 0; i < NE; i++) begin
         eng_req_addr_k[i*AW +: AW]   = ek[i];
         eng_req_addr_l[i*AW +: AW]   = el[i];
         eng_req_read_num[i*RW +: RW] = er[i];
      end
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge CLK_200M);
      #1;
   endtask

   task automatic do_reset;
      spl_reset = 1'b1;
      cyc();
      cyc();
      spl_reset = 1'b0;
   endtask

   task automatic push_req(input int e);
      req_t r;
      r.k  = ek[e];
      r.l  = el[e];
      r.rn = er[e];
      exp_req.push_back(r);
   endtask

   task automatic push_rsp(input logic [NE-1:0] oh, input logic [RW-1:0] rn,
                           input logic [511:0] k, input logic [511:0] l);
      rs_e.oh = oh;
      rs_e.rn = rn;
      rs_e.k  = k;
      rs_e.l  = l;
      exp_rsp.push_back(rs_e);
   endtask

   task automatic drive_rsp(input logic [511:0] k, input logic [511:0] l);
      mem_rsp_valid = 1'b1;
      mem_rsp_k     = k;
      mem_rsp_l     = l;
   endtask

   // Monitor: every DUT output strobe must match the head of its queue
   always @(negedge CLK_200M) begin
      if (!spl_reset) begin
         if (mem_req_valid) begin
            if (exp_req.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_mem_req actual=k:%0h rn:%0h required=none",
                        mem_req_addr_k, mem_req_read_num);
            end else begin
               rq_m = exp_req.pop_front();
               chk("mem_req_addr_k", 512'(mem_req_addr_k), 512'(rq_m.k));
               chk("mem_req_addr_l", 512'(mem_req_addr_l), 512'(rq_m.l));
               chk("mem_req_read_num", 512'(mem_req_read_num), 512'(rq_m.rn));
            end
         end
         if (eng_rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_eng_rsp actual=%0h required=0", eng_rsp_valid);
            end else begin
               rs_m = exp_rsp.pop_front();
               chk("eng_rsp_valid", 512'(eng_rsp_valid), 512'(rs_m.oh));
               chk("eng_rsp_read_num", 512'(eng_rsp_read_num), 512'(rs_m.rn));
               chk("eng_rsp_k", eng_rsp_k, rs_m.k);
               chk("eng_rsp_l", eng_rsp_l, rs_m.l);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stall = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_k = '0;
      mem_rsp_l = '0;
      for (int i = 0; i < NE; i++) begin
         ek[i] = '0;
         el[i] = '0;
         er[i] = '0;
      end

      // Reset state, including ready held low while engines request
      spl_reset = 1'b1;
      eng_req_valid = '1;
      cyc();
      cyc();
      chk("ready_in_reset", 512'(eng_req_ready), 512'(0));
      chk("rst_mem_req_valid", 512'(mem_req_valid), 512'(0));
      chk("rst_mem_req_addr_k", 512'(mem_req_addr_k), 512'(0));
      chk("rst_mem_req_read_num", 512'(mem_req_read_num), 512'(0));
      chk("rst_eng_rsp_valid", 512'(eng_rsp_valid), 512'(0));
      chk("rst_eng_rsp_k", eng_rsp_k, 512'(0));
      chk("rst_outstanding", 512'(outstanding), 512'(0));
      chk("rst_idle", 512'(idle), 512'(1));
      chk("rst_err_orphan", 512'(err_orphan), 512'(0));
      eng_req_valid = '0;
      spl_reset = 1'b0;

      // Single request from engine 2 and its response
      ek[2] = 58'h100;
      el[2] = 58'h104;
      er[2] = 6'd5;
      eng_req_valid[2] = 1'b1;
      #1;
      chk("single_ready", 512'(eng_req_ready), 512'(4'b0100));
      push_req(2);
      cyc();
      eng_req_valid[2] = 1'b0;
      chk("single_outstanding", 512'(outstanding), 512'(1));
      cyc();
      chk("single_not_idle", 512'(idle), 512'(0));
      drive_rsp(512'h1111_AAAA, 512'h2222_BBBB);
      push_rsp(4'b0100, 6'd5, 512'h1111_AAAA, 512'h2222_BBBB);
      cyc();
      mem_rsp_valid = 1'b0;
      chk("single_outstanding_back", 512'(outstanding), 512'(0));
      chk("single_idle", 512'(idle), 512'(1));
      cyc();
      chk("single_drain", 512'(exp_req.size() + exp_rsp.size()), 512'(0));

      // Fairness: all engines requesting, engine 0 first after reset
      do_reset();
      for (int i = 0; i < NE; i++) begin
         ek[i] = 58'h1000 + 58'(i);
         el[i] = 58'h2000 + 58'(i);
         er[i] = 6'(10 + i);
      end
      eng_req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr_ready", 512'(eng_req_ready), 512'(4'b0001 << (c % 4)));
         push_req(c % 4);
         cyc();
      end
      eng_req_valid = '0;
      cyc();
      chk("rr_drain", 512'(exp_req.size()), 512'(0));
      chk("rr_outstanding", 512'(outstanding), 512'(8));

      // Credit limit: 20 attempts, 16 grants, then one response frees a slot
      do_reset();
      grants = 0;
      ek[0] = 58'h3000;
      el[0] = 58'h5000;
      er[0] = 6'd0;
      eng_req_valid[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (eng_req_ready[0]) begin
            push_req(0);
            grants++;
            cyc();
            ek[0] = 58'h3000 + 58'(grants);
            el[0] = 58'h5000 + 58'(grants);
            er[0] = 6'(grants);
         end else begin
            cyc();
         end
      end
      chk("credit_grants", 512'(grants), 512'(16));
      chk("credit_outstanding", 512'(outstanding), 512'(16));
      chk("credit_ready_full", 512'(eng_req_ready), 512'(0));
      drive_rsp(512'h3333, 512'h4444);
      push_rsp(4'b0001, 6'd0, 512'h3333, 512'h4444);
      #1;
      chk("credit_ready_with_rsp", 512'(eng_req_ready), 512'(0));
      cyc();
      mem_rsp_valid = 1'b0;
      #1;
      chk("credit_regrant", 512'(eng_req_ready), 512'(4'b0001));
      push_req(0);
      cyc();
      eng_req_valid[0] = 1'b0;
      chk("credit_outstanding_refill", 512'(outstanding), 512'(16));
      cyc();
      chk("credit_drain", 512'(exp_req.size() + exp_rsp.size()), 512'(0));

      // Ordering: engines 1,3,1,0 with rn 1..4, responses return in order
      do_reset();
      for (int j = 0; j < 4; j++) begin
         ek[ord[j]] = 58'h400 + 58'(j + 1);
         el[ord[j]] = 58'h800 + 58'(j + 1);
         er[ord[j]] = 6'(j + 1);
         eng_req_valid[ord[j]] = 1'b1;
         #1;
         chk("order_ready", 512'(eng_req_ready), 512'(4'b0001 << ord[j]));
         push_req(ord[j]);
         cyc();
         eng_req_valid[ord[j]] = 1'b0;
      end
      cyc();
      for (int j = 0; j < 4; j++) begin
         drive_rsp(512'hA000_0000 + 512'(j), 512'hB000_0000 + 512'(j));
         push_rsp(4'b0001 << ord[j], 6'(j + 1),
                  512'hA000_0000 + 512'(j), 512'hB000_0000 + 512'(j));
         cyc();
      end
      mem_rsp_valid = 1'b0;
      cyc();
      chk("order_drain", 512'(exp_req.size() + exp_rsp.size()), 512'(0));
      chk("order_outstanding", 512'(outstanding), 512'(0));

      // Stall blocks grants; simultaneous grant+response keeps the count
      do_reset();
      ek[2] = 58'h600;
      el[2] = 58'h700;
      er[2] = 6'd0;
      eng_req_valid[2] = 1'b1;
      stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_ready", 512'(eng_req_ready), 512'(0));
         cyc();
      end
      stall = 1'b0;
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("stall_release_ready", 512'(eng_req_ready), 512'(4'b0100));
         push_req(2);
         cyc();
         ek[2] = 58'h600 + 58'(n + 1);
         el[2] = 58'h700 + 58'(n + 1);
         er[2] = 6'(n + 1);
      end
      #1;
      chk("simul_outstanding_before", 512'(outstanding), 512'(5));
      chk("simul_ready", 512'(eng_req_ready), 512'(4'b0100));
      drive_rsp(512'h5555, 512'h6666);
      push_rsp(4'b0100, 6'd0, 512'h5555, 512'h6666);
      push_req(2);
      cyc();
      mem_rsp_valid = 1'b0;
      eng_req_valid[2] = 1'b0;
      chk("simul_outstanding_after", 512'(outstanding), 512'(5));
      cyc();
      chk("simul_drain", 512'(exp_req.size() + exp_rsp.size()), 512'(0));

      // Orphan response: dropped, sticky flag until reset
      do_reset();
      drive_rsp(512'h7777, 512'h8888);
      cyc();
      mem_rsp_valid = 1'b0;
      chk("orphan_flag", 512'(err_orphan), 512'(1));
      cyc();
      chk("orphan_no_rsp", 512'(eng_rsp_valid), 512'(0));
      cyc();
      chk("orphan_sticky", 512'(err_orphan), 512'(1));
      chk("orphan_outstanding", 512'(outstanding), 512'(0));
      do_reset();
      chk("orphan_cleared", 512'(err_orphan), 512'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
